// File: rtl/rsa_verify_core.sv
// -----------------------------------------------------------------------------
// rsa_verify_core
//
// RSA signature check: computes signature^pub_exp mod modulus with MSB-first
// square-and-multiply over a bit-serial interleaved modular multiplier, then
// compares the result against the expected message hash.
//
// Ports
//   clk           clock
//   reset         asynchronous, active-high
//   start         request pulse, accepted only while busy=0
//   modulus       public modulus n (WIDTH bits)
//   pub_exp       public exponent e (EXP_W bits)
//   signature     signature s (WIDTH bits)
//   message_hash  expected hash h (HASH_W bits)
//   busy          operation in progress
//   done          one-cycle completion pulse
//   valid         signature accepted; held until the next accepted start
//   error         operand rejected; held until the next accepted start
//
// Configuration macro
//   RSA_VERIFY_FULLCMP_EN  defined: the full WIDTH-bit result must equal the
//                          zero-extended hash. Undefined: only the low HASH_W
//                          bits are compared.
// -----------------------------------------------------------------------------
module rsa_verify_core #(
    parameter int WIDTH  = 256,
    parameter int HASH_W = 128,
    parameter int EXP_W  = 17
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [WIDTH-1:0]  modulus,
    input  logic [EXP_W-1:0]  pub_exp,
    input  logic [WIDTH-1:0]  signature,
    input  logic [HASH_W-1:0] message_hash,
    output logic              busy,
    output logic              done,
    output logic              valid,
    output logic              error
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam int PTR_W = $clog2(EXP_W);

    typedef enum logic [2:0] {IDLE, CHECK, SQR, MUL, COMPARE} state_t;

    state_t              state, next_state;
    logic [WIDTH-1:0]    mod_reg, sig_reg, acc;
    logic [EXP_W-1:0]    exp_reg;
    logic [HASH_W-1:0]   hash_reg;
    logic [WIDTH+1:0]    t;          // partial product, always < n between steps
    logic [CNT_W-1:0]    bit_cnt;    // multiplier bit being consumed, MSB first
    logic [PTR_W-1:0]    ptr;        // exponent bit for the next square step

    logic [PTR_W-1:0]    msb;
    logic                bad, last, exp_bit, mul_bit, match;
    logic [WIDTH-1:0]    mul_b;
    logic [WIDTH+1:0]    n_ext, sum, red1, red2;

    // Index of the highest set exponent bit; a zero exponent is rejected in
    // CHECK, so the all-zero result never drives the schedule.
    always_comb begin
        msb = '0;
        for (int i = 0; i < EXP_W; i++) begin
            if (exp_reg[i]) msb = PTR_W'(i);
        end
    end

    assign bad = ~mod_reg[0] | (mod_reg < WIDTH'(2)) | (sig_reg >= mod_reg)
               | (exp_reg == '0);

    // One interleaved step: t = 2t + b[i]*a, then at most two subtractions.
    // With t < n and a < n the sum is below 3n, so two are always enough.
    assign last    = (bit_cnt == '0);
    assign exp_bit = exp_reg[ptr];
    assign mul_b   = (state == MUL) ? sig_reg : acc;
    assign mul_bit = mul_b[bit_cnt];
    assign n_ext   = {2'b00, mod_reg};
    assign sum     = (t << 1) + {2'b00, acc & {WIDTH{mul_bit}}};
    assign red1    = (sum  >= n_ext) ? sum  - n_ext : sum;
    assign red2    = (red1 >= n_ext) ? red1 - n_ext : red1;

`ifdef RSA_VERIFY_FULLCMP_EN
    assign match = (acc == WIDTH'(hash_reg));
`else
    assign match = (acc[HASH_W-1:0] == hash_reg);
`endif

    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the case leaves it unassigned and infers a latch.
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = CHECK;
            CHECK: begin
                if (bad)              next_state = IDLE;
                else if (msb == '0)   next_state = COMPARE;
                else                  next_state = SQR;
            end
            SQR: begin
                if (last) begin
                    if (exp_bit)          next_state = MUL;
                    else if (ptr == '0)   next_state = COMPARE;
                end
            end
            MUL: begin
                if (last) next_state = (ptr == '0) ? COMPARE : SQR;
            end
            COMPARE: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mod_reg  <= '0;
            sig_reg  <= '0;
            exp_reg  <= '0;
            hash_reg <= '0;
            acc      <= '0;
            t        <= '0;
            bit_cnt  <= '0;
            ptr      <= '0;
            done     <= 1'b0;
            valid    <= 1'b0;
            error    <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignment so every
            // right-hand side sees pre-edge values regardless of order.
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        mod_reg  <= modulus;
                        sig_reg  <= signature;
                        exp_reg  <= pub_exp;
                        hash_reg <= message_hash;
                        valid    <= 1'b0;
                        error    <= 1'b0;
                    end
                end
                CHECK: begin
                    if (bad) begin
                        error <= 1'b1;
                        done  <= 1'b1;
                    end else begin
                        acc     <= sig_reg;
                        ptr     <= msb - PTR_W'(1);
                        t       <= '0;
                        bit_cnt <= CNT_W'(WIDTH - 1);
                    end
                end
                SQR, MUL: begin
                    if (!last) begin
                        t       <= red2;
                        bit_cnt <= bit_cnt - CNT_W'(1);
                    end else begin
                        acc     <= red2[WIDTH-1:0];
                        t       <= '0;
                        bit_cnt <= CNT_W'(WIDTH - 1);
                        // Advance to the next exponent bit unless a multiply
                        // for the current bit is still pending.
                        if (((state == MUL) || !exp_bit) && (ptr != '0))
                            ptr <= ptr - PTR_W'(1);
                    end
                end
                COMPARE: begin
                    valid <= match;
                    done  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rsa_verify_core.sv
// -----------------------------------------------------------------------------
// tb_rsa_verify_core
//
// Self-checking bench for rsa_verify_core. Two instances with WIDTH=16: u0 has
// HASH_W=16, u1 has HASH_W=8 for the upper-bit comparison case. A reference
// model computes s^e mod n by repeated multiplication and predicts, per edge,
// busy/done/valid/error from the documented latency; a compare process checks
// every cycle, and directed and random transactions check results at done.
// -----------------------------------------------------------------------------
module tb_rsa_verify_core;

    localparam int W  = 16;
    localparam int EW = 17;

`ifdef RSA_VERIFY_FULLCMP_EN
    localparam bit FULL = 1'b1;
`else
    localparam bit FULL = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           reset;
    logic [1:0]     start_v;
    logic [W-1:0]   mod_v [2];
    logic [EW-1:0]  exp_v [2];
    logic [W-1:0]   sig_v [2];
    logic [15:0]    hash0;
    logic [7:0]     hash1;
    logic [1:0]     busy_v, done_v, valid_v, error_v;

    always #5 clk = ~clk;

    rsa_verify_core #(.WIDTH(W), .HASH_W(16), .EXP_W(EW)) dut0 (
        .clk(clk), .reset(reset), .start(start_v[0]),
        .modulus(mod_v[0]), .pub_exp(exp_v[0]), .signature(sig_v[0]),
        .message_hash(hash0),
        .busy(busy_v[0]), .done(done_v[0]), .valid(valid_v[0]), .error(error_v[0])
    );

    rsa_verify_core #(.WIDTH(W), .HASH_W(8), .EXP_W(EW)) dut1 (
        .clk(clk), .reset(reset), .start(start_v[1]),
        .modulus(mod_v[1]), .pub_exp(exp_v[1]), .signature(sig_v[1]),
        .message_hash(hash1),
        .busy(busy_v[1]), .done(done_v[1]), .valid(valid_v[1]), .error(error_v[1])
    );

    int checks = 0;
    int passed = 0;
    int cyc    = 0;
    bit running = 1'b0;

    // Reference model state per unit
    bit              m_active [2];
    int              m_done   [2];
    bit              m_rv     [2];
    bit              m_re     [2];

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic longint unsigned modexp(input longint unsigned s,
                                               input longint unsigned e,
                                               input longint unsigned n);
        longint unsigned r;
        if (n < 2) return 0;
        r = 1;
        for (longint unsigned i = 0; i < e; i++) r = (r * (s % n)) % n;
        return r;
    endfunction

    function automatic int latency(input longint unsigned e, input int w);
        int k;
        k = 0;
        for (int i = 0; i < 64; i++) if (e[i]) k = i;
        return 2 + (k + $countones(e) - 1) * w;
    endfunction

    function automatic bit is_bad(input longint unsigned n, input longint unsigned e,
                                  input longint unsigned s);
        return (n % 2 == 0) || (n <= 1) || (s >= n) || (e == 0);
    endfunction

    function automatic bit accepts(input longint unsigned res, input longint unsigned h,
                                   input int hw);
        if (FULL) return res == h;
        return (res % (64'd1 << hw)) == h;
    endfunction

    // Model update on each edge: accept start only when the unit was idle.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int u = 0; u < 2; u++) begin
                m_active[u] = 1'b0;
                m_rv[u]     = 1'b0;
                m_re[u]     = 1'b0;
                m_done[u]   = 0;
            end
        end else begin
            cyc++;
            for (int u = 0; u < 2; u++) begin
                if (start_v[u] && !(m_active[u] && (cyc - 1 < m_done[u]))) begin
                    longint unsigned n, e, s, h;
                    n = mod_v[u];
                    e = exp_v[u];
                    s = sig_v[u];
                    h = (u == 0) ? 64'(hash0) : 64'(hash1);
                    m_active[u] = 1'b1;
                    if (is_bad(n, e, s)) begin
                        m_re[u]   = 1'b1;
                        m_rv[u]   = 1'b0;
                        m_done[u] = cyc + 1;
                    end else begin
                        m_re[u]   = 1'b0;
                        m_rv[u]   = accepts(modexp(s, e, n), h, (u == 0) ? 16 : 8);
                        m_done[u] = cyc + latency(e, W);
                    end
                end
            end
        end
    end

    task automatic compare_unit(input int u);
        bit eb, ed, ev, ee;
        eb = m_active[u] && (cyc < m_done[u]);
        ed = m_active[u] && (cyc == m_done[u]);
        ev = m_active[u] && (cyc >= m_done[u]) && m_rv[u];
        ee = m_active[u] && (cyc >= m_done[u]) && m_re[u];
        check($sformatf("cyc%0d_u%0d_busy_done_valid_error", cyc, u),
              {busy_v[u], done_v[u], valid_v[u], error_v[u]}, {eb, ed, ev, ee});
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (running && !reset) begin
                compare_unit(0);
                compare_unit(1);
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic issue(input int u, input longint unsigned n, input longint unsigned e,
                         input longint unsigned s, input longint unsigned h,
                         output int s_edge);
        @(negedge clk);
        mod_v[u] = n[W-1:0];
        exp_v[u] = e[EW-1:0];
        sig_v[u] = s[W-1:0];
        if (u == 0) hash0 = h[15:0];
        else        hash1 = h[7:0];
        start_v[u] = 1'b1;
        @(negedge clk);
        start_v[u] = 1'b0;
        s_edge = cyc;
        // Operands are registered at start; scramble them afterwards.
        mod_v[u] = W'($urandom);
        exp_v[u] = EW'($urandom);
        sig_v[u] = W'($urandom);
        if (u == 0) hash0 = 16'($urandom);
        else        hash1 = 8'($urandom);
    endtask

    task automatic wait_done(input int u, input int budget, output int d_edge);
        int n;
        n = 0;
        d_edge = -1;
        while (n < budget) begin
            @(posedge clk);
            #2;
            if (done_v[u]) begin
                d_edge = cyc;
                break;
            end
            n++;
        end
        if (d_edge < 0) check($sformatf("timeout_u%0d", u), 0, 1);
    endtask

    task automatic directed(input string name, input int u, input longint unsigned n,
                            input longint unsigned e, input longint unsigned s,
                            input longint unsigned h, input int exp_lat,
                            input bit exp_valid, input bit exp_error);
        int s_edge, d_edge;
        issue(u, n, e, s, h, s_edge);
        wait_done(u, exp_lat + 20, d_edge);
        check({name, "_done_edge"}, d_edge - s_edge, exp_lat);
        check({name, "_valid"}, valid_v[u], exp_valid);
        check({name, "_error"}, error_v[u], exp_error);
        check({name, "_busy"}, busy_v[u], 0);
    endtask

    initial begin
        int s_edge, d_edge;
        reset   = 1'b1;
        start_v = '0;
        for (int u = 0; u < 2; u++) begin
            mod_v[u] = '0;
            exp_v[u] = '0;
            sig_v[u] = '0;
        end
        hash0 = '0;
        hash1 = '0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {busy_v, done_v, valid_v, error_v}, 0);
        reset   = 1'b0;
        running = 1'b1;

        // Pin the model with hand-known values
        check("model_65pow17_mod3233", modexp(65, 17, 3233), 2790);
        check("model_2790pow2753_mod3233", modexp(2790, 2753, 3233), 65);
        check("model_latency_e65537_w256", latency(65537, 256), 4354);
        check("model_latency_e17_w16", latency(17, 16), 82);

        directed("valid_sig",  0, 3233, 17, 65,   2790, 82, 1'b1, 1'b0);
        directed("wrong_hash", 0, 3233, 17, 65,   2791, 82, 1'b0, 1'b0);
        directed("s_eq_n",     0, 3233, 17, 3233, 2790, 1,  1'b0, 1'b1);
        directed("n_even",     0, 3234, 17, 65,   2790, 1,  1'b0, 1'b1);
        directed("e_zero",     0, 3233, 0,  65,   2790, 1,  1'b0, 1'b1);
        directed("n_one",      0, 1,    17, 0,    0,    1,  1'b0, 1'b1);
        directed("e_one",      0, 3233, 1,  100,  100,  2,  1'b1, 1'b0);
        directed("upper_bits", 1, 3233, 1,  'h105, 'h05, 2, !FULL, 1'b0);

        // Start while busy is ignored
        issue(0, 3233, 17, 65, 2790, s_edge);
        while (cyc < s_edge + 9) @(negedge clk);
        mod_v[0] = 3233;
        exp_v[0] = 17;
        sig_v[0] = 1;
        hash0    = 2790;
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        wait_done(0, 200, d_edge);
        check("ignored_start_done_edge", d_edge - s_edge, 82);
        check("ignored_start_valid", valid_v[0], 1);

        // Reset mid-operation, then a fresh run
        issue(0, 3233, 17, 65, 2790, s_edge);
        while (cyc < s_edge + 40) @(negedge clk);
        check("busy_before_reset", busy_v[0], 1);
        reset = 1'b1;
        #1;
        check("reset_async_outputs", {busy_v[0], done_v[0], valid_v[0], error_v[0]}, 0);
        @(negedge clk);
        reset = 1'b0;
        directed("after_reset", 0, 3233, 17, 65, 2790, 82, 1'b1, 1'b0);

        // Randomized transactions, issued back to back
        for (int i = 0; i < 40; i++) begin
            longint unsigned n, e, s, h, r;
            int sel, lat;
            bit bad, ok;
            n = $urandom_range(2, 65535);
            if ($urandom_range(0, 7) != 0) n = n | 1;
            if ($urandom_range(0, 7) == 0) s = $urandom_range(0, 65535);
            else                           s = $urandom_range(0, 32'(n - 1));
            sel = $urandom_range(0, 9);
            if (sel == 0)      e = 0;
            else if (sel == 1) e = 65537;
            else if (sel == 2) e = 1;
            else               e = $urandom_range(2, 100);
            bad = is_bad(n, e, s);
            r   = bad ? 0 : modexp(s, e, n);
            h   = ($urandom_range(0, 1) == 1) ? r : 64'($urandom_range(0, 65535));
            ok  = !bad && accepts(r, h, 16);
            lat = bad ? 1 : latency(e, W);
            issue(0, n, e, s, h, s_edge);
            wait_done(0, 400, d_edge);
            check($sformatf("rand%0d_done_edge", i), d_edge - s_edge, lat);
            check($sformatf("rand%0d_valid", i), valid_v[0], ok);
            check($sformatf("rand%0d_error", i), error_v[0], bad);
        end

        repeat (3) @(negedge clk);
        running = 1'b0;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
